// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// FETCH_HALT_EN adds the S_HALT state used when a halt word is fetched.
package fetch_pkg;

  localparam int unsigned INS_W = 14;

  localparam logic [INS_W-1:0] HALT_WORD = 14'h3FFF;
  localparam logic [INS_W-1:0] VOID_WORD = '0;

  typedef enum logic [1:0] {
    S_ADDR,
    S_LOAD,
`ifdef FETCH_HALT_EN
    S_STROBE,
    S_HALT
`else
    S_STROBE
`endif
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter with wrap-around increment, jump load and the pending
// jump-target latch (last request before consumption wins).
module fetch_pc
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W         = 10,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            advance_i,
  input  logic            redirect_i,
  input  logic            jump_req_i,
  input  logic [PC_W-1:0] jump_addr_i,
  output logic [PC_W-1:0] pc_o,
  output logic            jump_active_c_o,
  output logic [PC_W-1:0] jump_target_c_o
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] tgt_q, tgt_d;
  logic            pending_q, pending_d;

  // A live request overrides whatever target was latched earlier.
  assign jump_active_c_o = pending_q | jump_req_i;
  assign jump_target_c_o = jump_req_i ? jump_addr_i : tgt_q;
  assign pc_o            = pc_q;

  always_comb begin
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    pending_d = pending_q;
    if (redirect_i) begin
      pc_d      = jump_target_c_o;
      pending_d = 1'b0;
    end else begin
      if (jump_req_i) begin
        pending_d = 1'b1;
        tgt_d     = jump_addr_i;
      end
      if (advance_i) begin
        pc_d = pc_q + PC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= PC_W'(RESET_VECTOR);
      tgt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// Fetch FSM driving the ROM address and presenting words to the instruction
// register; FETCH_HALT_EN enables halting on HALT_WORD and the halted port.
module instruction_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned PC_W         = 10,
  parameter int unsigned RESET_VECTOR = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             jump_req,
  input  logic [PC_W-1:0]  jump_addr,
  output logic [PC_W-1:0]  rom_addr,
  input  logic [INS_W-1:0] rom_data,
  output logic [INS_W-1:0] ins_out,
  output logic             increment,
`ifdef FETCH_HALT_EN
  output logic             halted,
`endif
  output logic             is_void
);

  fetch_state_e     state_q;
  logic [INS_W-1:0] ins_out_q;
  logic             is_void_q;
  logic             increment_q;
  logic             jump_active_c;
  logic [PC_W-1:0]  jump_target_c;
  logic             advance_c;
  logic             redirect_c;

  assign advance_c = (state_q == S_LOAD) && !jump_active_c;
`ifdef FETCH_HALT_EN
  logic halted_q;
  assign halted     = halted_q;
  assign redirect_c = ((state_q == S_LOAD) || (state_q == S_HALT)) && jump_active_c;
`else
  assign redirect_c = (state_q == S_LOAD) && jump_active_c;
`endif

  fetch_pc #(
    .PC_W         (PC_W),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc (
    .clk             (clk),
    .reset           (reset),
    .advance_i       (advance_c),
    .redirect_i      (redirect_c),
    .jump_req_i      (jump_req),
    .jump_addr_i     (jump_addr),
    .pc_o            (rom_addr),
    .jump_active_c_o (jump_active_c),
    .jump_target_c_o (jump_target_c)
  );

  assign ins_out   = ins_out_q;
  assign is_void   = is_void_q;
  assign increment = increment_q;

  // The strobe rises one edge after S_STROBE so ins_out has a full cycle of setup.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_ADDR;
      ins_out_q   <= VOID_WORD;
      is_void_q   <= 1'b0;
      increment_q <= 1'b0;
`ifdef FETCH_HALT_EN
      halted_q    <= 1'b0;
`endif
    end else begin
      increment_q <= (state_q == S_STROBE);
      case (state_q)
        S_ADDR: begin
          if (!stall) state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (jump_active_c) begin
            ins_out_q <= VOID_WORD;
            is_void_q <= 1'b1;
          end else begin
            ins_out_q <= rom_data;
            is_void_q <= 1'b0;
          end
          state_q <= S_STROBE;
        end
        S_STROBE: begin
`ifdef FETCH_HALT_EN
          if (!is_void_q && (ins_out_q == HALT_WORD)) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= S_ADDR;
          end
        end
        S_HALT: begin
          if (jump_active_c) begin
            state_q  <= S_ADDR;
            halted_q <= 1'b0;
          end
`else
          state_q <= S_ADDR;
`endif
        end
        default: state_q <= S_ADDR;
      endcase
    end
  end

  logic unused_c;
  assign unused_c = ^jump_target_c;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Directed bench for instruction_fetch_sequencer with a strobe-stream model;
// define FETCH_HALT_EN to also exercise the halt feature.
module tb_instruction_fetch_sequencer;
  import fetch_pkg::*;

  localparam int unsigned PC_W = 10;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic             jump_req = 1'b0;
  logic [PC_W-1:0]  jump_addr = '0;
  logic [PC_W-1:0]  rom_addr;
  logic [INS_W-1:0] rom_data;
  logic [INS_W-1:0] ins_out;
  logic             increment;
  logic             is_void;
`ifdef FETCH_HALT_EN
  logic             halted;
`endif

  logic [INS_W-1:0] rom_mem [1<<PC_W];

  typedef struct {
    logic [INS_W-1:0] word;
    logic             void_f;
    int               gap;   // cycles since previous strobe; 0 = don't care
  } exp_t;

  exp_t             exp_q[$];
  logic [PC_W-1:0]  m_next;
  int               n_checks = 0;
  int               n_pass = 0;
  int               cyc = 0;

  instruction_fetch_sequencer #(
    .PC_W         (PC_W),
    .RESET_VECTOR (0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .jump_req  (jump_req),
    .jump_addr (jump_addr),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ins_out   (ins_out),
    .increment (increment),
`ifdef FETCH_HALT_EN
    .halted    (halted),
`endif
    .is_void   (is_void)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= rom_mem[rom_addr];
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: the register sees a stream of slots; each fetch reads the next
  // sequential address, each jump contributes one void slot and retargets it.
  function automatic void exp_fetch(input int gap);
    exp_q.push_back('{word: rom_mem[m_next], void_f: 1'b0, gap: gap});
    m_next = m_next + PC_W'(1);
  endfunction

  function automatic void exp_jump(input logic [PC_W-1:0] tgt, input int gap);
    exp_q.push_back('{word: '0, void_f: 1'b1, gap: gap});
    m_next = tgt;
  endfunction

  function automatic void exp_reset();
    exp_q.delete();
    m_next = '0;
  endfunction

  // Every strobe is checked against the model stream.
  initial begin : compare
    exp_t             e;
    int               last_cyc;
    logic [INS_W-1:0] prev_ins;
    last_cyc = 0;
    prev_ins = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        last_cyc = cyc;
      end else if (increment) begin
        if (exp_q.size() == 0) begin
          check("extra_strobe", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("strobe_word", 32'(ins_out), 32'(e.word));
          check("strobe_void", 32'(is_void), 32'(e.void_f));
          if (e.gap != 0) check("strobe_gap", 32'(cyc - last_cyc), 32'(e.gap));
          check("word_setup_stable", 32'(ins_out), 32'(prev_ins));
        end
        last_cyc = cyc;
      end
      prev_ins = ins_out;
    end
  end

  task automatic wait_strobe(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!increment && n < 40);
    if (!increment) begin
      n_checks++;
      $display("FAIL %s: no strobe within 40 cycles, got none required one", tag);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0;
    jump_req = 1'b0;
    exp_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_ins_out", 32'(ins_out), 32'(0));
    check("rst_is_void", 32'(is_void), 32'(0));
    check("rst_increment", 32'(increment), 32'(0));
    check("rst_rom_addr", 32'(rom_addr), 32'(0));
`ifdef FETCH_HALT_EN
    check("rst_halted", 32'(halted), 32'(0));
`endif
    reset = 1'b0;
  endtask

  task automatic pulse_jump(input logic [PC_W-1:0] a);
    jump_req  = 1'b1;
    jump_addr = a;
    @(negedge clk);
    jump_req  = 1'b0;
  endtask

  initial begin : stimulus
    logic [PC_W-1:0] hold_addr;
    for (int i = 0; i < (1 << PC_W); i++)
      rom_mem[i] = (i < 4) ? INS_W'((i + 1) * 'h11) : INS_W'(i ^ 'h1555);
`ifdef FETCH_HALT_EN
    rom_mem[5] = HALT_WORD;
`endif
    m_next = '0;

    // Sequential fetch with a 5-cycle stall before word 0x0033.
    do_reset();
    exp_fetch(3); exp_fetch(3); exp_fetch(8); exp_fetch(3);
    wait_strobe("seq0");
    check("lit_first_word", 32'(ins_out), 32'h0011);
    wait_strobe("seq1");
    check("lit_second_word", 32'(ins_out), 32'h0022);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_rom_addr", 32'(rom_addr), 32'(2));
      check("stall_no_strobe", 32'(increment), 32'(0));
    end
    stall = 1'b0;
    wait_strobe("seq2");
    check("lit_after_stall", 32'(ins_out), 32'h0033);
    wait_strobe("seq3");

    // Single jump to 0x100.
    do_reset();
    exp_fetch(3); exp_fetch(3); exp_jump(10'h100, 3); exp_fetch(3); exp_fetch(3);
    wait_strobe("j0");
    wait_strobe("j1");
    pulse_jump(10'h100);
    wait_strobe("j_void");
    check("lit_void_word", 32'(ins_out), 32'h0000);
    check("lit_void_flag", 32'(is_void), 32'(1));
    wait_strobe("j_tgt");
    check("lit_jump_target_word", 32'(ins_out), 32'h1455);
    wait_strobe("j_tgt1");

    // Two jumps while stalled (latched overwrite), then latched vs live in S_LOAD.
    do_reset();
    exp_fetch(3); exp_jump(10'h0C0, 5); exp_fetch(3); exp_fetch(3);
    exp_jump(10'h0C0, 3); exp_fetch(3);
    wait_strobe("d0");
    stall = 1'b1;
    jump_req = 1'b1; jump_addr = 10'h080;
    @(negedge clk);
    jump_addr = 10'h0C0;
    @(negedge clk);
    jump_req = 1'b0; stall = 1'b0;
    wait_strobe("d_void");
    wait_strobe("d_tgt");
    check("lit_last_jump_wins", 32'(ins_out), 32'h1595);
    wait_strobe("d_tgt1");
    jump_req = 1'b1; jump_addr = 10'h080;
    @(negedge clk);
    jump_addr = 10'h0C0;
    @(negedge clk);
    jump_req = 1'b0;
    wait_strobe("l_void");
    wait_strobe("l_tgt");
    check("lit_live_jump_wins", 32'(ins_out), 32'h1595);

    // PC wrap at 0x3FF, then reset asserted during S_LOAD.
    do_reset();
    exp_fetch(3); exp_jump(10'h3FE, 3); exp_fetch(3); exp_fetch(3); exp_fetch(3);
    wait_strobe("w0");
    pulse_jump(10'h3FE);
    wait_strobe("w_void");
    wait_strobe("w_3fe");
    wait_strobe("w_3ff");
    check("lit_3ff_word", 32'(ins_out), 32'h16AA);
    wait_strobe("w_wrap");
    check("lit_wrap_word", 32'(ins_out), 32'h0011);
    @(negedge clk);
    reset = 1'b1;
    exp_reset();
    #1;
    check("midrst_ins_out", 32'(ins_out), 32'(0));
    check("midrst_is_void", 32'(is_void), 32'(0));
    check("midrst_rom_addr", 32'(rom_addr), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_fetch(3); exp_fetch(3);
    wait_strobe("r0");
    check("lit_after_midrst", 32'(ins_out), 32'h0011);
    wait_strobe("r1");

`ifdef FETCH_HALT_EN
    // Halt on the all-ones word at address 5, then resume via jump to 0.
    do_reset();
    for (int i = 0; i < 6; i++) exp_fetch(3);
    for (int i = 0; i < 6; i++) wait_strobe("h_seq");
    check("lit_halt_word", 32'(ins_out), 32'h3FFF);
    hold_addr = rom_addr;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_no_strobe", 32'(increment), 32'(0));
      check("halt_flag", 32'(halted), 32'(1));
      check("halt_pc_frozen", 32'(rom_addr), 32'(hold_addr));
    end
    m_next = '0;
    exp_fetch(0); exp_fetch(3);
    pulse_jump(10'h000);
    check("halt_released", 32'(halted), 32'(0));
    wait_strobe("h_resume");
    check("lit_resume_word", 32'(ins_out), 32'h0011);
    check("lit_resume_not_void", 32'(is_void), 32'(0));
    wait_strobe("h_resume1");
`else
    hold_addr = '0;
`endif

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
